// File: rtl/bit_debounce_edge.sv
// Single-bit conditioner: synchroniser chain, stability-window debounce,
// registered rise/fall pulses and a wrapping edge-event counter with sticky overflow.
module bit_debounce_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf
);

    localparam int unsigned STAB_W = $clog2(STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    logic [STAB_W-1:0] stab_q, stab_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    state_e            state;

    // Stage 0 samples d; every later stage copies its predecessor.
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        if (g == 0) begin : g_first
            assign sync_d[g] = d;
        end else begin : g_next
            assign sync_d[g] = sync_q[g-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            stab_q  <= '0;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The qualification state is a decode of the stability counter itself.
    always_comb begin
        state = (stab_q == '0) ? IDLE : CHECK;
    end

    always_comb begin
        stab_d  = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (en && (s != level_q)) begin
            if (stab_q == STAB_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end

        // A clear wins over a same-cycle event, which is then dropped.
        if (clr_cnt) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rise_d || fall_d) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign busy    = (state == CHECK);
    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bit_debounce_edge.sv
// Bench for bit_debounce_edge: three parameterisations checked every cycle against
// a delay-line/run-length model, plus directed literal checks of key latencies.
module tb_bit_debounce_edge;

    localparam int NI = 3;
    int SS[NI] = '{2, 1, 1};
    int ST[NI] = '{4, 1, 1};
    int CW[NI] = '{8, 2, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_r[NI], d_r[NI], en_r[NI], clr_r[NI];
    logic lvl[NI], rs[NI], fl[NI], bsy[NI], ov[NI];
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;

    bit_debounce_edge u0 (
        .clk(clk), .rst(rst_r[0]), .d(d_r[0]), .en(en_r[0]), .clr_cnt(clr_r[0]),
        .level(lvl[0]), .rise(rs[0]), .fall(fl[0]), .busy(bsy[0]), .evt_cnt(cnt0), .ovf(ov[0])
    );

    bit_debounce_edge #(.SYNC_STAGES(1), .STABLE(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst_r[1]), .d(d_r[1]), .en(en_r[1]), .clr_cnt(clr_r[1]),
        .level(lvl[1]), .rise(rs[1]), .fall(fl[1]), .busy(bsy[1]), .evt_cnt(cnt1), .ovf(ov[1])
    );

    bit_debounce_edge #(.SYNC_STAGES(1), .STABLE(1)) u2 (
        .clk(clk), .rst(rst_r[2]), .d(d_r[2]), .en(en_r[2]), .clr_cnt(clr_r[2]),
        .level(lvl[2]), .rise(rs[2]), .fall(fl[2]), .busy(bsy[2]), .evt_cnt(cnt2), .ovf(ov[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int i);
        if (i == 0) return {24'd0, cnt0};
        if (i == 1) return {30'd0, cnt1};
        return {24'd0, cnt2};
    endfunction

    // Model: s is d delayed SYNC_STAGES edges; level flips once s has differed
    // from it for STABLE consecutive enabled cycles.
    logic [7:0] mh[NI];
    bit  ml[NI], mrise[NI], mfall[NI], movf[NI], armed[NI];
    int  mrun[NI], mcnt[NI];
    bit  ms, mev;

    initial for (int i = 0; i < NI; i++) armed[i] = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_r[i]) begin
                mh[i] = '1; ml[i] = 1'b1; mrun[i] = 0;
                mrise[i] = 1'b0; mfall[i] = 1'b0; mcnt[i] = 0; movf[i] = 1'b0;
                armed[i] = 1'b1;
            end else begin
                ms = mh[i][SS[i]-1];
                mev = 1'b0;
                mrise[i] = 1'b0; mfall[i] = 1'b0;
                if (en_r[i] && (ms != ml[i])) begin
                    mrun[i] = mrun[i] + 1;
                    if (mrun[i] == ST[i]) begin
                        ml[i] = ms; mrise[i] = ms; mfall[i] = !ms;
                        mrun[i] = 0; mev = 1'b1;
                    end
                end else begin
                    mrun[i] = 0;
                end
                if (clr_r[i]) begin
                    mcnt[i] = 0; movf[i] = 1'b0;
                end else if (mev) begin
                    if (mcnt[i] == (1 << CW[i]) - 1) movf[i] = 1'b1;
                    mcnt[i] = (mcnt[i] + 1) % (1 << CW[i]);
                end
                mh[i] = {mh[i][6:0], d_r[i]};
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (armed[i]) begin
                chk($sformatf("u%0d.level", i), 32'(lvl[i]), 32'(ml[i]));
                chk($sformatf("u%0d.rise", i),  32'(rs[i]),  32'(mrise[i]));
                chk($sformatf("u%0d.fall", i),  32'(fl[i]),  32'(mfall[i]));
                chk($sformatf("u%0d.busy", i),  32'(bsy[i]), 32'(mrun[i] != 0));
                chk($sformatf("u%0d.evt_cnt", i), dut_cnt(i), 32'(mcnt[i]));
                chk($sformatf("u%0d.ovf", i),   32'(ov[i]),  32'(movf[i]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_to(input int i, input logic dv);
        rst_r[i] = 1'b1; d_r[i] = dv;
        tick(2);
        rst_r[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_r[i] = 1'b1; d_r[i] = 1'b1; en_r[i] = 1'b1; clr_r[i] = 1'b0;
        end

        // Reset with d=0: fall six edges after release
        rst_to(0, 1'b0);
        rst_r[1] = 1'b0; rst_r[2] = 1'b0;
        chk("t1 level after rst", 32'(lvl[0]), 32'd1);
        chk("t1 rise after rst", 32'(rs[0]), 32'd0);
        chk("t1 fall after rst", 32'(fl[0]), 32'd0);
        tick(5);
        chk("t1 level edge5", 32'(lvl[0]), 32'd1);
        chk("t1 fall edge5", 32'(fl[0]), 32'd0);
        tick(1);
        chk("t1 level edge6", 32'(lvl[0]), 32'd0);
        chk("t1 fall edge6", 32'(fl[0]), 32'd1);
        chk("t1 evt_cnt", dut_cnt(0), 32'd1);
        chk("t1 ovf", 32'(ov[0]), 32'd0);
        tick(1);
        chk("t1 fall edge7", 32'(fl[0]), 32'd0);

        // Short glitch is rejected
        rst_to(0, 1'b1);
        tick(3);
        d_r[0] = 1'b0;
        tick(2); chk("t2 busy e2", 32'(bsy[0]), 32'd0);
        tick(1); chk("t2 busy e3", 32'(bsy[0]), 32'd1);
        d_r[0] = 1'b1;
        tick(1); chk("t2 busy e4", 32'(bsy[0]), 32'd1);
        tick(1); chk("t2 busy e5", 32'(bsy[0]), 32'd1);
        tick(1); chk("t2 busy e6", 32'(bsy[0]), 32'd0);
        chk("t2 level", 32'(lvl[0]), 32'd1);
        chk("t2 fall", 32'(fl[0]), 32'd0);
        tick(4);
        chk("t2 level late", 32'(lvl[0]), 32'd1);
        chk("t2 evt_cnt", dut_cnt(0), 32'd0);

        // Disabled qualification, then enable
        en_r[0] = 1'b0; d_r[0] = 1'b0;
        tick(10);
        chk("t3 level en0", 32'(lvl[0]), 32'd1);
        chk("t3 busy en0", 32'(bsy[0]), 32'd0);
        en_r[0] = 1'b1;
        tick(3);
        chk("t3 level e3", 32'(lvl[0]), 32'd1);
        chk("t3 busy e3", 32'(bsy[0]), 32'd1);
        tick(1);
        chk("t3 level e4", 32'(lvl[0]), 32'd0);
        chk("t3 fall e4", 32'(fl[0]), 32'd1);

        // Reset mid-qualification
        rst_to(0, 1'b1);
        tick(3);
        d_r[0] = 1'b0;
        tick(4);
        chk("t5 busy before rst", 32'(bsy[0]), 32'd1);
        rst_r[0] = 1'b1;
        tick(1);
        rst_r[0] = 1'b0;
        chk("t5 level", 32'(lvl[0]), 32'd1);
        chk("t5 busy", 32'(bsy[0]), 32'd0);
        chk("t5 fall", 32'(fl[0]), 32'd0);
        chk("t5 evt_cnt", dut_cnt(0), 32'd0);
        tick(5); chk("t5 fall e5", 32'(fl[0]), 32'd0);
        tick(1); chk("t5 fall e6", 32'(fl[0]), 32'd1);

        // Narrow counter wrap and clear priority
        rst_to(1, 1'b1);
        tick(2);
        for (int k = 1; k <= 4; k++) begin
            d_r[1] = ~d_r[1];
            tick(1); chk("t4 busy", 32'(bsy[1]), 32'd0);
            tick(1);
            chk($sformatf("t4 evt_cnt %0d", k), dut_cnt(1), 32'(k % 4));
            chk($sformatf("t4 ovf %0d", k), 32'(ov[1]), 32'(k == 4));
            chk($sformatf("t4 pulse %0d", k), 32'(rs[1] | fl[1]), 32'd1);
            tick(1);
        end
        d_r[1] = ~d_r[1];
        tick(1);
        clr_r[1] = 1'b1;
        tick(1);
        clr_r[1] = 1'b0;
        chk("t4 clr evt_cnt", dut_cnt(1), 32'd0);
        chk("t4 clr ovf", 32'(ov[1]), 32'd0);
        chk("t4 clr fall", 32'(fl[1]), 32'd1);

        // Minimum latency
        rst_to(2, 1'b1);
        tick(2);
        d_r[2] = 1'b0;
        tick(1);
        chk("t6 busy e1", 32'(bsy[2]), 32'd0);
        chk("t6 level e1", 32'(lvl[2]), 32'd1);
        tick(1);
        chk("t6 level e2", 32'(lvl[2]), 32'd0);
        chk("t6 fall e2", 32'(fl[2]), 32'd1);
        chk("t6 busy e2", 32'(bsy[2]), 32'd0);

        // Random traffic on all instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(5) == 0) d_r[i] = ~d_r[i];
                en_r[i]  = ($urandom_range(15) != 0);
                clr_r[i] = ($urandom_range(99) == 0);
                rst_r[i] = ($urandom_range(299) == 0);
            end
            tick(1);
        end
        for (int i = 0; i < NI; i++) begin
            rst_r[i] = 1'b0; clr_r[i] = 1'b0;
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
